data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 4, access latency in cycles (legal range 1..15).
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_i  input  1  access request from pipeline MEM stage, held until ready_o.
REQ-006 SHALL have port we_i  input  1  1 = write (MemWrite), 0 = read (MemRead).
REQ-007 SHALL have port addr_i  input  32  byte address (ALU result).
REQ-008 SHALL have port wdata_i  input  32  store data.
REQ-009 SHALL have port ready_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata_o  output  32  load data, valid while ready_o=1.
REQ-011 SHALL have port stall_o  output  1  freeze request to PC/pipeline registers.
REQ-012 SHALL have port err_o  output  1  access fault, valid while ready_o=1.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL, in IDLE with req_i=1, latch addr_i, we_i and wdata_i, load counter with LATENCY-1, and go to BUSY.
REQ-015 SHALL, in BUSY, go to DONE when counter=0, else decrement the counter; req_i, addr_i, we_i and wdata_i are ignored in BUSY.
REQ-016 SHALL go from DONE to IDLE unconditionally; ready_o=1 only in DONE, so ready_o asserts exactly LATENCY cycles after the accepting edge.
REQ-017 SHALL compute word index as latched addr[31:2]; index >= DEPTH_WORDS is out-of-range.
REQ-018 SHALL, for an in-range write, update the word at the edge entering DONE; rdata_o=0 in DONE.
REQ-019 SHALL, for an in-range read, register the stored word into rdata_o at the edge entering DONE.
REQ-020 SHALL, for an out-of-range access, set err_o=1 and rdata_o=0 in DONE, with no memory update.
REQ-021 SHALL drive stall_o = (IDLE and req_i) or BUSY, combinationally; stall_o=0 in DONE.
REQ-022 SHALL hold rdata_o and err_o at 0 outside DONE.
REQ-023 SHALL accept a new request only in IDLE; a req_i held high through DONE is accepted as a new access at the first IDLE edge.

Reset
REQ-024 SHALL, with rst_i=1 at an edge, enter IDLE, clear the counter and latched fields, and drive ready_o=0, rdata_o=0, err_o=0; stall_o=0 while rst_i=1.
REQ-025 SHALL abort an in-flight access on reset with no memory update; memory contents are not cleared by reset.
REQ-026 SHALL give rst_i priority over req_i at the same edge.

Configuration
REQ-027 SHALL support macro DMEM_ALIGN_CHECK_EN: when defined, an access with addr[1:0]!=0 is treated as a fault (err_o=1, no write, rdata_o=0).
REQ-028 SHALL, without DMEM_ALIGN_CHECK_EN, ignore addr[1:0]; only range faults set err_o.

Structure
REQ-029 SHALL place the FSM state enum, default DEPTH_WORDS/LATENCY, and counter width constant in shared package dmem_pkg.
REQ-030 SHALL instantiate one sub-module dmem_array: synchronous single-read, single-write 32-bit storage with DEPTH_WORDS entries.

Verification
REQ-031 SHALL cover: reset, then write 0xDEADBEEF to 0x10 (LATENCY=4) -> stall_o=1 for 4 cycles, ready_o pulses 4 cycles after acceptance, err_o=0.
REQ-032 SHALL cover: read from 0x10 after REQ-031 -> rdata_o=0xDEADBEEF with ready_o, err_o=0.
REQ-033 SHALL cover: read 0x400 with DEPTH_WORDS=256 -> err_o=1, rdata_o=0, and a subsequent read of 0x0 is unaffected.
REQ-034 SHALL cover: rst_i pulsed during BUSY of write 0x12345678 to 0x20 -> no ready_o, and a later read of 0x20 returns the prior value.
REQ-035 SHALL cover: addr 0x13 with DMEM_ALIGN_CHECK_EN -> err_o=1, no write; without the macro -> access to word 4 succeeds.
REQ-036 SHALL cover: LATENCY=1 with req_i held across back-to-back reads of 0x0 and 0x4 -> ready_o every third cycle, correct data each time.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM state encoding,
// default geometry/latency and the latency counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_LATENCY     = 4;
  // LATENCY is limited to 1..15, so LATENCY-1 always fits in four bits.
  localparam int CNT_W           = 4;

endpackage

// File: rtl/dmem_array.sv
// Synchronous 32-bit word storage with one write port and one registered read port.
// Contents are never cleared; only the read register changes on a read enable.
module dmem_array #(
  parameter int DEPTH_WORDS = dmem_pkg::DEF_DEPTH_WORDS,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for a pipeline MEM stage (IDLE/BUSY/DONE).
// Optional macro DMEM_ALIGN_CHECK_EN makes any access with addr[1:0] != 0 a fault.
// Handshake: req_i is held with stable fields until ready_o; ready_o is a one-cycle
// pulse in DONE, and rdata_o/err_o are meaningful only while ready_o=1 (0 otherwise).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [29:0]      idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic             fault;
  logic             finish;
  logic [31:0]      arr_rdata;

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign fault = ({2'b00, idx_q} >= 32'(DEPTH_WORDS)) || mis_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];
  assign fault = ({2'b00, idx_q} >= 32'(DEPTH_WORDS));
`endif

  // The array acts only on the edge that enters DONE; reset at that edge aborts it.
  assign finish = (state_q == ST_BUSY) && (cnt_q == '0) && !rst_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          idx_d   = addr_i[31:2];
          wdata_d = wdata_i;
          we_d    = we_i;
          cnt_d   = CNT_W'(LATENCY - 1);
`ifdef DMEM_ALIGN_CHECK_EN
          mis_d   = (addr_i[1:0] != 2'b00);
`endif
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          err_d   = fault;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (finish && we_q && !fault),
    .re_i   (finish && !we_q && !fault),
    .addr_i (idx_q[AW-1:0]),
    .wdata_i(wdata_q),
    .rdata_o(arr_rdata)
  );

  assign ready_o     = (state_q == ST_DONE);
  assign err_o       = err_q;
  assign rdata_o     = (ready_o && !we_q && !err_q) ? arr_rdata : 32'd0;
  assign stall_o     = !rst_i && (((state_q == ST_IDLE) && req_i) || (state_q == ST_BUSY));
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 uses LATENCY=4, instance 1 uses LATENCY=1.
// Expected results come from a word-array model of the memory and its fault rules.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, req, we, ready, stall, err;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  dbg [2];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model [2][DEPTH];
  bit          known [2][DEPTH];
  logic [31:0] exp_q [$];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .ready_o(ready[0]), .rdata_o(rdata[0]), .stall_o(stall[0]),
    .err_o(err[0]), .dbg_state_o(dbg[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .ready_o(ready[1]), .rdata_o(rdata[1]), .stall_o(stall[1]),
    .err_o(err[1]), .dbg_state_o(dbg[1])
  );

  // Reference behaviour of one access; updates the model for successful writes.
  function automatic void predict(input int sel, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, output logic e_err,
                                  output logic [31:0] e_rd, output bit chk);
    int unsigned idx;
    idx   = a >> 2;
    e_err = (idx >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) e_err = 1'b1;
`endif
    e_rd = 32'd0;
    chk  = 1'b1;
    if (w) begin
      if (!e_err) begin
        model[sel][idx] = d;
        known[sel][idx] = 1'b1;
      end
    end else if (!e_err) begin
      chk  = known[sel][idx];
      e_rd = model[sel][idx];
    end
  endfunction

  task automatic access(input int sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int lat);
    logic        e_err;
    logic [31:0] e_rd;
    logic [31:0] exp_rd;
    bit          chk;
    bit          seen;
    int          n;
    predict(sel, w, a, d, e_err, e_rd, chk);
    if (chk) exp_q.push_back(e_rd);
    @(negedge clk);
    req[sel] = 1'b1; we[sel] = w; addr[sel] = a; wdata[sel] = d;
    #1;
    vectors++;
    if (stall[sel] !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_on_req dut%0d: got %b want 1", sel, stall[sel]);
    end
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (ready[sel] === 1'b1) seen = 1'b1;
      else begin
        vectors++;
        if (stall[sel] !== 1'b1 || err[sel] !== 1'b0 || rdata[sel] !== 32'd0) begin
          miscompares++;
          $display("FAIL busy_outputs dut%0d cyc %0d: stall=%b err=%b rdata=%h want 1/0/0",
                   sel, n, stall[sel], err[sel], rdata[sel]);
        end
      end
    end
    vectors++;
    if (!seen || n != lat + 1) begin
      miscompares++;
      $display("FAIL latency dut%0d addr=%h: ready after %0d edges (seen=%b) want %0d",
               sel, a, n, seen, lat + 1);
    end
    if (chk) begin
      exp_rd = exp_q.pop_front();
      if (seen) begin
        vectors++;
        if (rdata[sel] !== exp_rd) begin
          miscompares++;
          $display("FAIL rdata dut%0d addr=%h we=%b: got %h want %h", sel, a, w, rdata[sel], exp_rd);
        end
      end
    end
    if (seen) begin
      vectors++;
      if (err[sel] !== e_err || stall[sel] !== 1'b0) begin
        miscompares++;
        $display("FAIL done_flags dut%0d addr=%h: err=%b stall=%b want err=%b stall=0",
                 sel, a, err[sel], stall[sel], e_err);
      end
    end
    req[sel] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 2'b11; req = 2'b11;
    addr[0] = 32'h0; addr[1] = 32'h0; we = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (stall[s] !== 1'b0 || ready[s] !== 1'b0 || err[s] !== 1'b0 || rdata[s] !== 32'd0 ||
          dbg[s] !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: stall=%b ready=%b err=%b rdata=%h state=%0d want all 0",
                 s, stall[s], ready[s], err[s], rdata[s], dbg[s]);
      end
    end
    rst = 2'b00; req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (dbg[s] !== 2'd0 || stall[s] !== 1'b0 || ready[s] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_priority dut%0d: state=%0d stall=%b ready=%b want idle/0/0",
                 s, dbg[s], stall[s], ready[s]);
      end
    end
  endtask

  task automatic test_write_read();
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4);
    access(0, 1'b0, 32'h10, 32'h0, 4);
  endtask

  task automatic test_out_of_range();
    access(0, 1'b1, 32'h0, 32'h0BAD_F00D, 4);
    access(0, 1'b0, 32'h400, 32'h0, 4);
    access(0, 1'b1, 32'h404, 32'hFFFF_FFFF, 4);
    access(0, 1'b0, 32'h0, 32'h0, 4);
  endtask

  task automatic test_reset_abort();
    int n_ready;
    access(0, 1'b1, 32'h20, 32'hCAFEF00D, 4);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
    repeat (3) @(negedge clk);
    rst[0] = 1'b1; req[0] = 1'b0;
    #1;
    vectors++;
    if (stall[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_in_reset: got %b want 0", stall[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    n_ready = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready[0] === 1'b1) n_ready++;
      @(negedge clk);
    end
    vectors++;
    if (n_ready != 0 || dbg[0] !== 2'd0) begin
      miscompares++;
      $display("FAIL abort_no_ready: ready pulses=%0d state=%0d want 0/idle", n_ready, dbg[0]);
    end
    access(0, 1'b0, 32'h20, 32'h0, 4);
  endtask

  task automatic test_align();
    access(0, 1'b1, 32'h10, 32'h11111111, 4);
    access(0, 1'b1, 32'h13, 32'h22222222, 4);
    access(0, 1'b0, 32'h10, 32'h0, 4);
    access(0, 1'b0, 32'h13, 32'h0, 4);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 32'h47F);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      access(0, 1'($urandom_range(0, 1)), a, $urandom, 4);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int n, hits;
    r1 = $urandom; r2 = $urandom;
    access(1, 1'b1, 32'h0, r1, 1);
    access(1, 1'b1, 32'h4, r2, 1);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    n = 0; hits = 0;
    while (hits < 2 && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (ready[1] === 1'b1) begin
        hits++;
        vectors++;
        if (n != 3 * hits - 1 || rdata[1] !== (hits == 1 ? r1 : r2) || err[1] !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_ready%0d: at edge %0d rdata=%h err=%b want edge %0d rdata=%h err=0",
                   hits, n, rdata[1], err[1], 3 * hits - 1, (hits == 1 ? r1 : r2));
        end
        addr[1] = 32'h4;
      end
    end
    req[1] = 1'b0;
    vectors++;
    if (hits != 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d ready pulses want 2", hits);
    end
  endtask

  initial begin
    rst = 2'b11; req = 2'b00; we = 2'b00;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_reset_abort();
    test_align();
    test_random();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
